// File: rtl/ycc_pkg.sv
// Shared YCbCr types: 8-bit sample, 4:4:4 pixel, and the internal pair/hold records
// used by the 4:2:2 -> 4:4:4 upsampler.
package ycc_pkg;

  typedef logic [7:0] pix_t;

  localparam pix_t CHROMA_NEUTRAL = 8'd128;

  typedef struct packed {
    pix_t y;
    pix_t cb;
    pix_t cr;
  } ycc444_t;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  // Even sample waiting for its odd partner; single marks an odd-width line end.
  typedef struct packed {
    logic v;
    logic single;
    pix_t y;
    pix_t c;
  } coll_t;

  typedef struct packed {
    logic v;
    logic eol;
    pix_t y_e;
    pix_t y_o;
    pix_t cb;
    pix_t cr;
  } pend_t;

  typedef struct packed {
    logic    v;
    logic    sub;
    logic    single;
    logic    eol;
    ycc444_t ev;
    ycc444_t od;
  } hold_t;

  function automatic hold_t load_pair(input pix_t y_e, input pix_t y_o,
                                      input pix_t cb, input pix_t cr,
                                      input pix_t cb_o, input pix_t cr_o,
                                      input logic eol);
    hold_t h;
    h.v      = 1'b1;
    h.sub    = 1'b0;
    h.single = 1'b0;
    h.eol    = eol;
    h.ev     = '{y: y_e, cb: cb, cr: cr};
    h.od     = '{y: y_o, cb: cb_o, cr: cr_o};
    return h;
  endfunction

  function automatic hold_t load_single(input pix_t y, input pix_t cb, input pix_t cr);
    hold_t h;
    h.v      = 1'b1;
    h.sub    = 1'b0;
    h.single = 1'b1;
    h.eol    = 1'b1;
    h.ev     = '{y: y, cb: cb, cr: cr};
    h.od     = '0;
    return h;
  endfunction

endpackage

// File: rtl/chroma_avg.sv
// Rounded average of two 8-bit chroma samples; the 9-bit sum cannot overflow.
module chroma_avg (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] avg
);

  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    avg = sum[8:1];
  end

endmodule

// File: rtl/yuv422_to_444.sv
// 4:2:2 -> 4:4:4 chroma upsampler. Define YUV422_CHROMA_INTERP_EN for interpolated
// odd-pixel chroma; the default build replicates the pair's chroma.
module yuv422_to_444 #(
  parameter logic [7:0] CHROMA_NEUTRAL = ycc_pkg::CHROMA_NEUTRAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_y,
  input  logic [7:0] in_c,
  input  logic       in_eol,
  output logic       data_out_valid,
  output logic [7:0] y_out,
  output logic [7:0] cb_out,
  output logic [7:0] cr_out,
  output logic       eol_out
);
  import ycc_pkg::*;

  phase_e  phase_q, phase_d;
  coll_t   coll_q, coll_d;
  hold_t   hold_q, hold_d;
  ycc444_t out_q, out_d;
  logic    out_v_q, out_v_d;
  logic    out_eol_q, out_eol_d;
  logic    rdy_q, rdy_d;

  pix_t avg_cb_a, avg_cb_b, avg_cr_a, avg_cr_b, avg_cb, avg_cr;
  logic xfer, odd_xfer, even_xfer, hold_free, coll_single;

`ifdef YUV422_CHROMA_INTERP_EN
  pend_t      pend_q, pend_d;
  logic [1:0] lock_q, lock_d;
`endif

  // Replicate mode feeds both inputs the same value, which averages to itself.
  chroma_avg u_avg_cb (.a(avg_cb_a), .b(avg_cb_b), .avg(avg_cb));
  chroma_avg u_avg_cr (.a(avg_cr_a), .b(avg_cr_b), .avg(avg_cr));

  assign xfer        = in_valid && rdy_q;
  assign odd_xfer    = xfer && (phase_q == PH_ODD);
  assign even_xfer   = xfer && (phase_q == PH_EVEN);
  assign hold_free   = !hold_q.v || hold_q.sub || hold_q.single;
  assign coll_single = coll_q.v && coll_q.single;

  always_comb begin
    phase_d = phase_q;
    if (xfer) begin
      phase_d = in_eol ? PH_EVEN : ((phase_q == PH_EVEN) ? PH_ODD : PH_EVEN);
    end
  end

  always_comb begin
    hold_d    = hold_q;
    coll_d    = coll_q;
    out_d     = out_q;
    out_v_d   = 1'b0;
    out_eol_d = 1'b0;
    avg_cb_a  = coll_q.c;
    avg_cb_b  = coll_q.c;
    avg_cr_a  = in_c;
    avg_cr_b  = in_c;
`ifdef YUV422_CHROMA_INTERP_EN
    pend_d    = pend_q;
`endif

    if (hold_q.v) begin
      out_v_d = 1'b1;
      if (!hold_q.sub) begin
        out_d     = hold_q.ev;
        out_eol_d = hold_q.single;
        if (hold_q.single) begin
          hold_d.v = 1'b0;
        end else begin
          hold_d.sub = 1'b1;
        end
      end else begin
        out_d      = hold_q.od;
        out_eol_d  = hold_q.eol;
        hold_d.v   = 1'b0;
        hold_d.sub = 1'b0;
      end
    end

`ifdef YUV422_CHROMA_INTERP_EN
    // A completed pair parks in pend until its successor supplies the interpolation
    // partner; an eol flushes pend with replicated (or half-interpolated) chroma.
    if (odd_xfer) begin
      if (pend_q.v) begin
        avg_cb_a = pend_q.cb;
        avg_cr_a = pend_q.cr;
        hold_d   = load_pair(pend_q.y_e, pend_q.y_o, pend_q.cb, pend_q.cr,
                             avg_cb, avg_cr, 1'b0);
        pend_d   = '{v: 1'b1, eol: in_eol, y_e: coll_q.y, y_o: in_y,
                     cb: coll_q.c, cr: in_c};
      end else if (in_eol) begin
        hold_d = load_pair(coll_q.y, in_y, coll_q.c, in_c, avg_cb, avg_cr, 1'b1);
      end else begin
        pend_d = '{v: 1'b1, eol: 1'b0, y_e: coll_q.y, y_o: in_y,
                   cb: coll_q.c, cr: in_c};
      end
    end else if (hold_free && pend_q.v && (pend_q.eol || coll_single)) begin
      avg_cb_a = pend_q.cb;
      avg_cb_b = pend_q.eol ? pend_q.cb : coll_q.c;
      avg_cr_a = pend_q.cr;
      avg_cr_b = pend_q.cr;
      hold_d   = load_pair(pend_q.y_e, pend_q.y_o, pend_q.cb, pend_q.cr,
                           avg_cb, avg_cr, pend_q.eol);
      pend_d.v = 1'b0;
    end else if (hold_free && coll_single && !pend_q.v) begin
      hold_d   = load_single(coll_q.y, coll_q.c, CHROMA_NEUTRAL);
      coll_d.v = 1'b0;
    end
`else
    if (odd_xfer) begin
      hold_d = load_pair(coll_q.y, in_y, coll_q.c, in_c, avg_cb, avg_cr, in_eol);
    end else if (hold_free && coll_single) begin
      hold_d   = load_single(coll_q.y, coll_q.c, CHROMA_NEUTRAL);
      coll_d.v = 1'b0;
    end
`endif

    if (even_xfer) begin
      coll_d = '{v: 1'b1, single: in_eol, y: in_y, c: in_c};
    end else if (odd_xfer) begin
      coll_d.v = 1'b0;
    end
  end

`ifdef YUV422_CHROMA_INTERP_EN
  always_comb begin
    lock_d = lock_q;
    if (xfer && in_eol) begin
      lock_d = 2'd2;
    end else if (lock_q != 2'd0) begin
      lock_d = lock_q - 2'd1;
    end
    rdy_d = (lock_d == 2'd0);
  end
`else
  always_comb begin
    rdy_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_EVEN;
      coll_q    <= '0;
      hold_q    <= '0;
      out_q     <= '0;
      out_v_q   <= 1'b0;
      out_eol_q <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef YUV422_CHROMA_INTERP_EN
      pend_q    <= '0;
      lock_q    <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      coll_q    <= coll_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      out_v_q   <= out_v_d;
      out_eol_q <= out_eol_d;
      rdy_q     <= rdy_d;
`ifdef YUV422_CHROMA_INTERP_EN
      pend_q    <= pend_d;
      lock_q    <= lock_d;
`endif
    end
  end

  assign in_ready       = rdy_q;
  assign data_out_valid = out_v_q;
  assign y_out          = out_q.y;
  assign cb_out         = out_q.cb;
  assign cr_out         = out_q.cr;
  assign eol_out        = out_eol_q;

endmodule

// File: tb/tb_yuv422_to_444.sv
// Randomized bench for yuv422_to_444 against a per-line list model of the upsampling rules.
module tb_yuv422_to_444;

`ifdef YUV422_CHROMA_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  localparam logic [7:0] NEUTRAL = 8'd128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_y = '0;
  logic [7:0] in_c = '0;
  logic       in_eol = 1'b0;
  logic       data_out_valid;
  logic [7:0] y_out, cb_out, cr_out;
  logic       eol_out;

  always #5 clk = ~clk;

  yuv422_to_444 #(.CHROMA_NEUTRAL(NEUTRAL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_c(in_c), .in_eol(in_eol), .data_out_valid(data_out_valid),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out), .eol_out(eol_out)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  bit          tog = 1'b0;

  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  int unsigned got_edge[$];
  int unsigned acc_edge[$];
  logic [7:0]  line_y[$];
  logic [7:0]  line_c[$];
  logic [7:0]  stim_y[$];
  logic [7:0]  stim_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && data_out_valid) begin
      got_q.push_back({eol_out, y_out, cb_out, cr_out});
      got_edge.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ravg(input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    s = (int'(a) + int'(b) + 1) / 2;
    return s[7:0];
  endfunction

  // Expected pixels of one complete line, straight from the pairing/chroma rules.
  task automatic model_line();
    int unsigned n;
    logic [7:0] cb, cr, cbo, cro;
    n = line_y.size();
    for (int unsigned i = 0; i + 1 < n; i += 2) begin
      cb  = line_c[i];
      cr  = line_c[i+1];
      cbo = cb;
      cro = cr;
      if (INTERP && i + 3 < n) begin
        cbo = ravg(cb, line_c[i+2]);
        cro = ravg(cr, line_c[i+3]);
      end else if (INTERP && i + 2 < n) begin
        cbo = ravg(cb, line_c[i+2]);
      end
      exp_q.push_back({1'b0, line_y[i], cb, cr});
      exp_q.push_back({(i + 2 == n), line_y[i+1], cbo, cro});
    end
    if (n % 2 == 1) exp_q.push_back({1'b1, line_y[n-1], line_c[n-1], NEUTRAL});
    line_y.delete();
    line_c.delete();
  endtask

  // mode 0: back-to-back, 1: in_valid toggles every cycle, 2: random gaps
  task automatic send(input logic [7:0] y, input logic [7:0] c, input logic eol,
                      input int unsigned mode);
    int unsigned guard = 0;
    logic ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      tog = ~tog;
      if ((mode == 1 && !tog) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_y     = y;
        in_c     = c;
        in_eol   = eol;
        ok       = in_ready;
      end
      guard++;
      if (!ok && guard > 64) begin
        check("ready_timeout", {31'd0, in_ready}, 32'd1);
        ok = 1'b1;
      end
    end
    acc_edge.push_back(cyc + 1);
    line_y.push_back(y);
    line_c.push_back(c);
  endtask

  task automatic send_line(input int unsigned mode);
    for (int unsigned i = 0; i < stim_y.size(); i++) begin
      send(stim_y[i], stim_c[i], (i + 1 == stim_y.size()), mode);
    end
    model_line();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic eol_ready_check();
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("ready_after_eol%0d", i), {31'd0, in_ready},
            (INTERP && i < 2) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic check_pix(input string tag, input int unsigned idx, input logic [24:0] exp);
    if (idx < got_q.size()) check(tag, got_q[idx], exp);
    else check({tag, "_missing"}, got_q.size(), idx + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, ab, len, nmin;

    repeat (3) @(negedge clk);
    check("reset_outs", {in_ready, data_out_valid, eol_out, y_out, cb_out, cr_out}, 32'd0);
    rst_n = 1'b1;
    check("ready_at_release", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_rise", {31'd0, in_ready}, 32'd1);

    // 4-sample reference line, with latency and in_ready-after-eol checks
    stim_y = '{8'd10, 8'd20, 8'd30, 8'd40};
    stim_c = '{8'd100, 8'd200, 8'd110, 8'd210};
    base = got_q.size();
    ab   = acc_edge.size();
    send_line(0);
    eol_ready_check();
    idle(8);
    check("line4_count", got_q.size() - base, 32'd4);
    if (got_edge.size() >= base + 4) begin
      check("lat_first", got_edge[base], acc_edge[ab + (INTERP ? 3 : 1)] + 1);
      check("lat_last", got_edge[base+3], acc_edge[ab + 3] + (INTERP ? 4 : 2));
    end
    check_pix("line4_p0", base, {1'b0, 8'd10, 8'd100, 8'd200});
    check_pix("line4_p1", base + 1,
              INTERP ? {1'b0, 8'd20, 8'd105, 8'd205} : {1'b0, 8'd20, 8'd100, 8'd200});
    check_pix("line4_p3", base + 3, {1'b1, 8'd40, 8'd110, 8'd210});

    // odd-width line
    stim_y = '{8'd10, 8'd20, 8'd30};
    stim_c = '{8'd100, 8'd200, 8'd110};
    base = got_q.size();
    send_line(0);
    idle(10);
    check("odd_count", got_q.size() - base, 32'd3);
    check_pix("odd_last", base + 2, {1'b1, 8'd30, 8'd110, NEUTRAL});

    // in_valid toggling every cycle
    stim_y = '{8'd10, 8'd20, 8'd30, 8'd40};
    stim_c = '{8'd100, 8'd200, 8'd110, 8'd210};
    base = got_q.size();
    send_line(1);
    idle(10);
    check("toggle_count", got_q.size() - base, 32'd4);
    check_pix("toggle_p2", base + 2, {1'b0, 8'd30, 8'd110, 8'd210});

    // reset mid-line discards the partial pair
    send(8'd99, 8'd99, 1'b0, 0);
    line_y.delete();
    line_c.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outs", {in_ready, data_out_valid, eol_out, y_out, cb_out, cr_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    stim_y = '{8'd50, 8'd60};
    stim_c = '{8'd70, 8'd80};
    base = got_q.size();
    send_line(0);
    idle(10);
    check("post_reset_count", got_q.size() - base, 32'd2);
    check_pix("post_reset_p0", base, {1'b0, 8'd50, 8'd70, 8'd80});
    check_pix("post_reset_p1", base + 1, {1'b1, 8'd60, 8'd70, 8'd80});

    // saturated chroma on adjacent pairs
    stim_y = '{8'd1, 8'd2, 8'd3, 8'd4};
    stim_c = '{8'd255, 8'd255, 8'd255, 8'd255};
    base = got_q.size();
    send_line(0);
    idle(10);
    check_pix("cb255_p1", base + 1, {1'b0, 8'd2, 8'd255, 8'd255});

    // randomized lines
    for (int unsigned l = 0; l < 150; l++) begin
      len = $urandom_range(1, 9);
      stim_y.delete();
      stim_c.delete();
      for (int unsigned i = 0; i < len; i++) begin
        stim_y.push_back(8'($urandom_range(0, 255)));
        stim_c.push_back(8'($urandom_range(0, 255)));
      end
      send_line(($urandom_range(0, 1) == 0) ? 0 : 2);
      idle($urandom_range(0, 3));
    end
    idle(20);

    check("pix_count", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int unsigned i = 0; i < nmin; i++) begin
      check($sformatf("pix%0d", i), got_q[i], exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/yuv422_to_444.md
YUV422_TO_444 -- requirements
Module: yuv422_to_444

Interface
REQ-001 Parameter: CHROMA_NEUTRAL, default 8'd128, chroma value substituted for a missing Cr sample.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  an input sample is presented.
REQ-005 in_ready  output  1  block accepts the sample; transfer occurs when in_valid && in_ready at clk rise.
REQ-006 in_y  input  8  luma of the current sample.
REQ-007 in_c  input  8  chroma of the current sample; Cb on even line positions, Cr on odd positions.
REQ-008 in_eol  input  1  current sample is the last one of its line.
REQ-009 data_out_valid  output  1  one 4:4:4 pixel presented this cycle; no backpressure.
REQ-010 y_out, cb_out, cr_out  output  8 each  4:4:4 pixel to the colour-space converter.
REQ-011 eol_out  output  1  marks the last pixel of a line.

Function
REQ-012 Input order per line SHALL be Y0/Cb0, Y1/Cr0, Y2/Cb2, Y3/Cr2, ...; a phase bit SHALL track even/odd position, toggle on every transfer, and clear after an eol transfer.
REQ-013 An even+odd pair SHALL be assembled in a collection register, then moved to a hold register when the odd sample transfers.
REQ-014 Each held pair SHALL be emitted as 2 consecutive output cycles: even pixel (Y_even, Cb, Cr), then odd pixel (Y_odd, Cb', Cr').
REQ-015 Replicate mode: Cb' = Cb and Cr' = Cr; odd sample accepted at edge N -> even pixel registered at N+1, odd pixel at N+2; in_ready held at 1.
REQ-016 Interpolate mode: Cb' = (Cb_k + Cb_k+1 + 1) >> 1 and Cr' likewise, using 9-bit sums with no overflow; pair k SHALL be emitted only after pair k+1 completes or an eol is seen.
REQ-017 Interpolate mode latency: pair k+1 odd accepted at edge M -> pair k pixels at M+1 and M+2.
REQ-018 Interpolate mode eol: the final pair uses replicated chroma; pending pair at M+1/M+2, final pair at M+3/M+4; with no pending pair (2-pixel line), final pair at M+1/M+2.
REQ-019 Interpolate mode: in_ready SHALL be 0 for exactly the 2 cycles following an eol transfer.
REQ-020 An eol on an even-position sample (odd-width line) SHALL emit that single pixel with Cr = CHROMA_NEUTRAL and Cb' unused; no odd pixel is emitted.
REQ-021 eol_out SHALL be 1 only on the last emitted pixel of a line.
REQ-022 data_out_valid SHALL be 0 in every cycle with no pixel to emit; outputs hold their last values.
REQ-023 Input gaps (in_valid = 0) SHALL stall assembly without corrupting the phase bit or held pairs.

Reset
REQ-024 On rst_n low, all outputs SHALL be 0 and in_ready 0, phase even, and pending/hold registers invalid; in_ready SHALL rise 1 cycle after rst_n deasserts.
REQ-025 Reset mid-line SHALL discard partial pairs; the next transfer is treated as position 0.

Configuration
REQ-026 Macro YUV422_CHROMA_INTERP_EN: when defined, interpolate mode (REQ-016 to REQ-019) is used.
REQ-027 When the macro is undefined, replicate mode (REQ-015) is used, with no pending-pair register and no in_ready deassertion.

Structure
REQ-028 A shared package ycc_pkg SHALL hold CHROMA_NEUTRAL, the 8-bit pixel typedef and the 4:4:4 pixel struct.
REQ-029 Sub-module chroma_avg SHALL perform the rounded 2-input 8-bit average; it is combinational and instantiated twice (Cb, Cr).

Verification
REQ-030 Replicate mode: 4-sample line Y=10,20,30,40; C=100,200,110,210 with eol on sample 4 -> pixels (10,100,200),(20,100,200),(30,110,210),(40,110,210), eol_out on the 4th pixel.
REQ-031 Interpolate mode, same stimulus -> (10,100,200),(20,105,205),(30,110,210),(40,110,210); in_ready low 2 cycles after eol.
REQ-032 Odd-width line of 3 samples with eol on Y=30/Cb=110 -> 3rd pixel (30,110,128) with eol_out=1.
REQ-033 in_valid toggling 1/0 every cycle over a 4-sample line -> identical pixel values to REQ-030; data_out_valid count = 4.
REQ-034 rst_n pulsed after 1 sample of a line, then a fresh 2-sample line -> no output from the partial line; new line emitted correctly.
REQ-035 Interpolate mode, Cb=255 and 255 on adjacent pairs -> Cb'=255, no wrap.
